// File: rtl/pwm_pkg.sv
// Shared definitions for the LED PWM / fade-control slice: duty width,
// FSM state encoding, default tick divider and the per-channel step helper.
package pwm_pkg;

  localparam int DUTY_W = 8;

  // 10 ms fade tick at 25 MHz.
  localparam int unsigned TICK_DIV_DEFAULT = 250000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [DUTY_W-1:0] r;
    logic [DUTY_W-1:0] g;
    logic [DUTY_W-1:0] b;
  } rgb_t;

  // Move cur one step toward tgt, clamped so it never passes tgt. The sum and
  // difference carry a ninth bit, so a large step near 255 or 0 shows up as
  // overflow/borrow instead of silently wrapping.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] step
  );
    logic [DUTY_W:0]   up;
    logic [DUTY_W:0]   dn;
    logic [DUTY_W-1:0] res;
    up  = {1'b0, cur} + {1'b0, step};
    dn  = {1'b0, cur} - {1'b0, step};
    res = cur;
    if (cur < tgt) begin
      res = (up >= {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
    end else if (cur > tgt) begin
      res = (dn[DUTY_W] || (dn[DUTY_W-1:0] <= tgt)) ? tgt : dn[DUTY_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every DIV enabled cycles. Holds its count
// while en is low; clr restarts the phase. Also used for keypad debounce.
module tick_gen
  import pwm_pkg::*;
#(
  parameter int unsigned DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_last;

  assign at_last = (count_q == CNT_W'(DIV - 1));
  assign tick    = en && at_last;

  // Next count: clear wins, otherwise count 0..DIV-1 and wrap while enabled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = at_last ? '0 : count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rgb_fade_ctrl.sv
// RGB fade controller: latches a target colour on a valid strobe and ramps the
// three PWM duties toward it by STEP on every fade tick, pulsing done on arrival.
module rgb_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned STEP     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] target_r,
  input  logic [DUTY_W-1:0] target_g,
  input  logic [DUTY_W-1:0] target_b,
  input  logic              target_valid,
  input  logic              freeze,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic              busy,
  output logic              done
);

  localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);

  logic [1:0] state_q, state_d;
  rgb_t       tgt_q, tgt_d;
  rgb_t       duty_q, duty_d;
  rgb_t       tgt_in;
  logic       tick;
  logic       tick_clr;
  logic       tick_en;
  logic       at_target;

  assign tgt_in    = '{r: target_r, g: target_g, b: target_b};
  assign at_target = (duty_q == tgt_q);
  // The prescaler only advances while ramping and not frozen.
  assign tick_en   = (state_q == ST_RAMP) && !freeze;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .en    (tick_en),
    .tick  (tick)
  );

  // FSM next state, target latching and per-tick duty stepping.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    duty_d   = duty_q;
    tick_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (target_valid) begin
          tgt_d    = tgt_in;
          tick_clr = 1'b1;
          state_d  = ST_RAMP;
        end
      end
      ST_RAMP: begin
        // tick is already gated by freeze, so frozen duties stay put.
        if (tick) begin
          duty_d.r = step_toward(duty_q.r, tgt_q.r, STEP_V);
          duty_d.g = step_toward(duty_q.g, tgt_q.g, STEP_V);
          duty_d.b = step_toward(duty_q.b, tgt_q.b, STEP_V);
        end
        // A retarget keeps the current duties and tick phase; arrival is
        // then judged against the new target from the next cycle on.
        if (target_valid) begin
          tgt_d = tgt_in;
        end else if (at_target) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A strobe during the done pulse starts a fresh ramp straight away.
        if (target_valid) begin
          tgt_d    = tgt_in;
          tick_clr = 1'b1;
          state_d  = ST_RAMP;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, target and duty registers; reset overrides any strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
    end
  end

  assign duty_r = duty_q.r;
  assign duty_g = duty_q.g;
  assign duty_b = duty_q.b;
  assign busy   = (state_q == ST_RAMP) || (state_q == ST_DONE);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Scoreboard bench for rgb_fade_ctrl: stimulus pushes expected output events
// (duty change or done pulse, with the cycle they must appear in); monitors
// pop and compare whenever the DUT presents such an event.
module tb_rgb_fade_ctrl;

  typedef struct {
    int         cyc;   // -1: cycle not checked
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       done;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       mon_en = 1'b0;

  // DUT 1: TICK_DIV=4, STEP=1
  logic [7:0] t1_r, t1_g, t1_b;
  logic       v1, frz1;
  logic [7:0] d1_r, d1_g, d1_b;
  logic       busy1, done1;
  // DUT 2: TICK_DIV=4, STEP=100
  logic [7:0] t2_r, t2_g, t2_b;
  logic       v2, frz2;
  logic [7:0] d2_r, d2_g, d2_b;
  logic       busy2, done2;

  evt_t q1[$];
  evt_t q2[$];
  logic [7:0] p1_r, p1_g, p1_b, p2_r, p2_g, p2_b;

  rgb_fade_ctrl #(.TICK_DIV(4), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .target_r(t1_r), .target_g(t1_g), .target_b(t1_b),
    .target_valid(v1), .freeze(frz1),
    .duty_r(d1_r), .duty_g(d1_g), .duty_b(d1_b),
    .busy(busy1), .done(done1)
  );

  rgb_fade_ctrl #(.TICK_DIV(4), .STEP(100)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .target_r(t2_r), .target_g(t2_g), .target_b(t2_b),
    .target_valid(v2), .freeze(frz2),
    .duty_r(d2_r), .duty_g(d2_g), .duty_b(d2_b),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack_evt(input int c, input logic [7:0] r,
                                           input logic [7:0] g, input logic [7:0] b,
                                           input logic d);
    return {7'd0, c[31:0], r, g, b, d};
  endfunction

  task automatic push1(input int c, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic d);
    evt_t e;
    e = '{cyc: c, r: r, g: g, b: b, done: d};
    q1.push_back(e);
  endtask

  task automatic push2(input int c, input logic [7:0] r, input logic d);
    evt_t e;
    e = '{cyc: c, r: r, g: 8'd0, b: 8'd0, done: d};
    q2.push_back(e);
  endtask

  task automatic compare_evt(input string name, input evt_t e, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b, input logic d);
    int ec;
    ec = (e.cyc < 0) ? cyc : e.cyc;
    check(name, pack_evt(cyc, r, g, b, d), pack_evt(ec, e.r, e.g, e.b, e.done));
  endtask

  // Monitor for DUT 1: any duty change or done pulse must match the queue head.
  always @(negedge clk) begin
    if (mon_en && ({d1_r, d1_g, d1_b} !== {p1_r, p1_g, p1_b} || done1 !== 1'b0)) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut1_unexpected_evt: got rgb=%0d,%0d,%0d done=%0b required no event (cyc=%0d)",
                 d1_r, d1_g, d1_b, done1, cyc);
      end else begin
        compare_evt("dut1_evt", q1.pop_front(), d1_r, d1_g, d1_b, done1);
      end
    end
    {p1_r, p1_g, p1_b} = {d1_r, d1_g, d1_b};
  end

  // Monitor for DUT 2 (red channel only is exercised, green/blue must stay 0).
  always @(negedge clk) begin
    if (mon_en && ({d2_r, d2_g, d2_b} !== {p2_r, p2_g, p2_b} || done2 !== 1'b0)) begin
      if (q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut2_unexpected_evt: got rgb=%0d,%0d,%0d done=%0b required no event (cyc=%0d)",
                 d2_r, d2_g, d2_b, done2, cyc);
      end else begin
        compare_evt("dut2_evt", q2.pop_front(), d2_r, d2_g, d2_b, done2);
      end
    end
    {p2_r, p2_g, p2_b} = {d2_r, d2_g, d2_b};
  end

  // Advance to 1 time unit after the edge that makes cyc == c.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle strobe, raised now (just after an edge), sampled on the next edge.
  task automatic strobe(input int sel, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    if (sel == 1) begin
      {t1_r, t1_g, t1_b} = {r, g, b};
      v1 = 1'b1;
    end else begin
      {t2_r, t2_g, t2_b} = {r, g, b};
      v2 = 1'b1;
    end
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time (cyc=%0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    rst_n = 1'b0;
    {t1_r, t1_g, t1_b, v1, frz1} = '0;
    {t2_r, t2_g, t2_b, v2, frz2} = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_duty1", {40'd0, d1_r, d1_g, d1_b}, 64'd0);
    check("rst_busy_done1", {62'd0, busy1, done1}, 64'd0);
    check("rst_duty2", {40'd0, d2_r, d2_g, d2_b}, 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_until(cyc + 2);

    // Basic ramp to (3,0,0): a step every 4 cycles, done one cycle after arrival
    t0 = cyc;
    push1(t0 + 5, 8'd1, 8'd0, 8'd0, 1'b0);
    push1(t0 + 9, 8'd2, 8'd0, 8'd0, 1'b0);
    push1(t0 + 13, 8'd3, 8'd0, 8'd0, 1'b0);
    push1(t0 + 14, 8'd3, 8'd0, 8'd0, 1'b1);
    strobe(1, 8'd3, 8'd0, 8'd0);
    check("basic_busy_ramp", {63'd0, busy1}, 64'd1);
    wait_until(t0 + 14);
    check("basic_busy_done", {63'd0, busy1}, 64'd1);
    wait_until(t0 + 15);
    check("basic_busy_idle", {63'd0, busy1}, 64'd0);
    wait_until(t0 + 20);

    // Retarget mid-ramp: green rising to 40, retargeted to 5 once it reaches 10
    t0 = cyc;
    for (int k = 1; k <= 10; k++) push1(t0 + 1 + 4 * k, 8'd3, 8'(k), 8'd0, 1'b0);
    for (int k = 1; k <= 5; k++) push1(t0 + 41 + 4 * k, 8'd3, 8'(10 - k), 8'd0, 1'b0);
    push1(t0 + 62, 8'd3, 8'd5, 8'd0, 1'b1);
    strobe(1, 8'd3, 8'd40, 8'd0);
    wait_until(t0 + 42);
    strobe(1, 8'd3, 8'd5, 8'd0);
    check("retarget_busy", {63'd0, busy1}, 64'd1);
    wait_until(t0 + 70);

    // Freeze for 20 cycles mid-ramp: blue's next step slips by exactly 20 cycles
    t0 = cyc;
    push1(t0 + 5, 8'd3, 8'd5, 8'd1, 1'b0);
    push1(t0 + 9, 8'd3, 8'd5, 8'd2, 1'b0);
    for (int k = 3; k <= 20; k++) push1(t0 + 21 + 4 * k, 8'd3, 8'd5, 8'(k), 1'b0);
    push1(t0 + 102, 8'd3, 8'd5, 8'd20, 1'b1);
    strobe(1, 8'd3, 8'd5, 8'd20);
    wait_until(t0 + 10);
    frz1 = 1'b1;
    wait_until(t0 + 30);
    check("freeze_busy", {63'd0, busy1}, 64'd1);
    frz1 = 1'b0;
    wait_until(t0 + 110);

    // Target equal to current duties -> done on the 2nd edge; strobe in DONE -> RAMP
    t0 = cyc;
    push1(t0 + 2, 8'd3, 8'd5, 8'd20, 1'b1);
    push1(-1, 8'd2, 8'd5, 8'd20, 1'b0);
    push1(-1, 8'd1, 8'd5, 8'd20, 1'b0);
    push1(-1, 8'd0, 8'd5, 8'd20, 1'b0);
    push1(-1, 8'd0, 8'd5, 8'd20, 1'b1);
    strobe(1, 8'd3, 8'd5, 8'd20);
    check("equal_busy_ramp", {63'd0, busy1}, 64'd1);
    wait_until(t0 + 2);
    strobe(1, 8'd0, 8'd5, 8'd20);
    check("done_strobe_busy", {63'd0, busy1}, 64'd1);
    check("done_strobe_duty", {40'd0, d1_r, d1_g, d1_b}, {40'd0, 8'd3, 8'd5, 8'd20});
    wait_until(t0 + 40);
    check("done_strobe_idle", {63'd0, busy1}, 64'd0);

    // Reset during RAMP with a coincident strobe: all zero, strobe ignored
    t0 = cyc;
    push1(t0 + 5, 8'd1, 8'd6, 8'd19, 1'b0);
    push1(t0 + 9, 8'd2, 8'd7, 8'd18, 1'b0);
    push1(t0 + 11, 8'd0, 8'd0, 8'd0, 1'b0);
    strobe(1, 8'd10, 8'd10, 8'd10);
    wait_until(t0 + 10);
    rst_n = 1'b0;
    {t1_r, t1_g, t1_b} = {8'd200, 8'd200, 8'd200};
    v1 = 1'b1;
    wait_until(t0 + 11);
    rst_n = 1'b1;
    v1 = 1'b0;
    check("rst_mid_busy_done", {62'd0, busy1, done1}, 64'd0);
    wait_until(t0 + 40);
    check("rst_mid_stays_idle", {63'd0, busy1}, 64'd0);

    // STEP=100: clamp at the top of the range and at zero, no wrap either way
    t0 = cyc;
    push2(t0 + 5, 8'd100, 1'b0);
    push2(t0 + 9, 8'd200, 1'b0);
    push2(t0 + 13, 8'd250, 1'b0);
    push2(t0 + 14, 8'd250, 1'b1);
    strobe(2, 8'd250, 8'd0, 8'd0);
    wait_until(t0 + 20);
    t0 = cyc;
    push2(t0 + 5, 8'd255, 1'b0);
    push2(t0 + 6, 8'd255, 1'b1);
    strobe(2, 8'd255, 8'd0, 8'd0);
    wait_until(t0 + 12);
    t0 = cyc;
    push2(t0 + 5, 8'd155, 1'b0);
    push2(t0 + 9, 8'd55, 1'b0);
    push2(t0 + 13, 8'd50, 1'b0);
    push2(t0 + 14, 8'd50, 1'b1);
    strobe(2, 8'd50, 8'd0, 8'd0);
    wait_until(t0 + 20);
    t0 = cyc;
    push2(t0 + 5, 8'd0, 1'b0);
    push2(t0 + 6, 8'd0, 1'b1);
    strobe(2, 8'd0, 8'd0, 8'd0);
    wait_until(t0 + 12);

    // Every expected event must have been seen
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
